// File: rtl/fmap_stream_collector_pkg.sv
// Shared types, default layer geometry and width helpers for the feature-map
// collector and its index counter.
package fmap_stream_collector_pkg;

   localparam int DEF_BITWIDTH    = 8;
   localparam int DEF_DATAWIDTH   = 28;
   localparam int DEF_DATAHEIGHT  = 28;
   localparam int DEF_DATACHANNEL = 3;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

   // A counter over a single value still needs one bit to exist.
   function automatic int index_width(input int count);
      return (count > 1) ? clog2(count) : 1;
   endfunction

endpackage

// File: rtl/fmap_index_counter.sv
// Nested col/row/ch counter walking a CHANNEL x HEIGHT x WIDTH frame in
// stream order, with its linear slot index and end-of-frame flag.
module fmap_index_counter
   import fmap_stream_collector_pkg::*;
#(
   parameter int DATAWIDTH   = DEF_DATAWIDTH,
   parameter int DATAHEIGHT  = DEF_DATAHEIGHT,
   parameter int DATACHANNEL = DEF_DATACHANNEL,
   parameter int COL_W       = index_width(DATAWIDTH),
   parameter int ROW_W       = index_width(DATAHEIGHT),
   parameter int CH_W        = index_width(DATACHANNEL),
   parameter int IDX_W       = index_width(DATAWIDTH*DATAHEIGHT*DATACHANNEL)
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             restart,
   output logic [COL_W-1:0] col,
   output logic [ROW_W-1:0] row,
   output logic [CH_W-1:0]  ch,
   output logic [IDX_W-1:0] idx,
   output logic             last
);

   localparam int PIXELS = DATAWIDTH*DATAHEIGHT*DATACHANNEL;

   logic [COL_W-1:0] col_q, base_col, col_next;
   logic [ROW_W-1:0] row_q, base_row, row_next;
   logic [CH_W-1:0]  ch_q,  base_ch,  ch_next;

   // A restart means the current beat sits at slot 0, so step from zero.
   always_comb begin
      base_col = restart ? '0 : col_q;
      base_row = restart ? '0 : row_q;
      base_ch  = restart ? '0 : ch_q;
      col_next = base_col;
      row_next = base_row;
      ch_next  = base_ch;
      if (base_col == COL_W'(DATAWIDTH - 1)) begin
         col_next = '0;
         if (base_row == ROW_W'(DATAHEIGHT - 1)) begin
            row_next = '0;
            if (base_ch == CH_W'(DATACHANNEL - 1)) begin
               ch_next = '0;
            end else begin
               ch_next = base_ch + 1'b1;
            end
         end else begin
            row_next = base_row + 1'b1;
         end
      end else begin
         col_next = base_col + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q <= '0;
         row_q <= '0;
         ch_q  <= '0;
      end else if (enable) begin
         col_q <= col_next;
         row_q <= row_next;
         ch_q  <= ch_next;
      end
   end

   assign col  = col_q;
   assign row  = row_q;
   assign ch   = ch_q;
   assign idx  = IDX_W'(ch_q) * IDX_W'(DATAHEIGHT*DATAWIDTH)
               + IDX_W'(row_q) * IDX_W'(DATAWIDTH)
               + IDX_W'(col_q);
   assign last = (idx == IDX_W'(PIXELS - 1));

endmodule

// File: rtl/fmap_stream_collector.sv
// Gathers a streamed feature map into a packed frame for the max-pool stage
// and holds it until the consumer takes it.
module fmap_stream_collector
   import fmap_stream_collector_pkg::*;
#(
   parameter int BITWIDTH    = DEF_BITWIDTH,
   parameter int DATAWIDTH   = DEF_DATAWIDTH,
   parameter int DATAHEIGHT  = DEF_DATAHEIGHT,
   parameter int DATACHANNEL = DEF_DATACHANNEL,
   parameter int RELU        = 0
)(
   input  logic                                              clk,
   input  logic                                              rst_n,
   input  logic                                              in_valid,
   output logic                                              in_ready,
   input  logic [BITWIDTH-1:0]                               in_data,
   input  logic                                              in_sof,
   output logic                                              out_valid,
   input  logic                                              out_ready,
   output logic [BITWIDTH*DATAWIDTH*DATAHEIGHT*DATACHANNEL-1:0] out_data,
   output logic                                              sof_err
);

   localparam int PIXELS       = DATAWIDTH*DATAHEIGHT*DATACHANNEL;
   localparam int FRAME_W      = BITWIDTH*PIXELS;
   localparam int COL_W        = index_width(DATAWIDTH);
   localparam int ROW_W        = index_width(DATAHEIGHT);
   localparam int CH_W         = index_width(DATACHANNEL);
   localparam int IDX_W        = index_width(PIXELS);
   localparam bit SINGLE_PIXEL = (PIXELS == 1);

   state_t state, state_next;

   logic [FRAME_W-1:0]  frame_q;
   logic                out_valid_q;
   logic                sof_err_q;
   logic [COL_W-1:0]    col;
   logic [ROW_W-1:0]    row;
   logic [CH_W-1:0]     ch;
   logic [IDX_W-1:0]    idx;
   logic                last;
   logic                accept;
   logic                restart;
   logic                at_start;
   logic                beat_last;
   logic [IDX_W-1:0]    wr_idx;
   logic [BITWIDTH-1:0] pixel;

   assign accept    = in_valid && (state == FILL);
   assign restart   = accept && in_sof;
   assign at_start  = (col == '0) && (row == '0) && (ch == '0);
   assign wr_idx    = in_sof ? '0 : idx;
   assign beat_last = in_sof ? SINGLE_PIXEL : last;
   assign pixel     = ((RELU != 0) && in_data[BITWIDTH-1]) ? '0 : in_data;

   fmap_index_counter #(
      .DATAWIDTH   (DATAWIDTH),
      .DATAHEIGHT  (DATAHEIGHT),
      .DATACHANNEL (DATACHANNEL),
      .COL_W       (COL_W),
      .ROW_W       (ROW_W),
      .CH_W        (CH_W),
      .IDX_W       (IDX_W)
   ) index_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (accept),
      .restart (restart),
      .col     (col),
      .row     (row),
      .ch      (ch),
      .idx     (idx),
      .last    (last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FILL;
      end else begin
         state <= state_next;
      end
   end

   // The input side is only open while filling, so a held frame can't be overwritten.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      case (state)
         FILL: begin
            in_ready = 1'b1;
            if (in_valid && beat_last) begin
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_next = FILL;
            end
         end
         default: state_next = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         sof_err_q   <= 1'b0;
      end else begin
         out_valid_q <= (state_next == HOLD);
         sof_err_q   <= restart && !at_start;
      end
   end

   // Slots are only ever overwritten; stale pixels persist across frames.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_q <= '0;
      end else if (accept) begin
         for (int i = 0; i < PIXELS; i++) begin
            if (wr_idx == IDX_W'(i)) begin
               frame_q[i*BITWIDTH +: BITWIDTH] <= pixel;
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = frame_q;
   assign sof_err   = sof_err_q;

endmodule

// File: tb/tb_fmap_stream_collector.sv
// Directed bench for the feature-map collector: a 4x2x2 instance checked every
// cycle against a frame-level model, plus small RELU and 1x1x1 instances.
module tb_fmap_stream_collector;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   logic         in_valid = 1'b0;
   logic         in_sof = 1'b0;
   logic         out_ready = 1'b0;
   logic [7:0]   in_data = 8'h00;
   logic         in_ready;
   logic         out_valid;
   logic         sof_err;
   logic [127:0] out_data;

   logic         r_in_valid = 1'b0;
   logic         r_in_sof = 1'b0;
   logic         r_out_ready = 1'b0;
   logic [7:0]   r_in_data = 8'h00;
   logic         r_in_ready;
   logic         r_out_valid;
   logic         r_sof_err;
   logic [31:0]  r_out_data;

   logic         u_in_valid = 1'b0;
   logic         u_in_sof = 1'b0;
   logic         u_out_ready = 1'b0;
   logic [7:0]   u_in_data = 8'h00;
   logic         u_in_ready;
   logic         u_out_valid;
   logic         u_sof_err;
   logic [7:0]   u_out_data;

   fmap_stream_collector #(
      .BITWIDTH(8), .DATAWIDTH(4), .DATAHEIGHT(2), .DATACHANNEL(2), .RELU(0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_sof(in_sof), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .sof_err(sof_err)
   );

   fmap_stream_collector #(
      .BITWIDTH(8), .DATAWIDTH(2), .DATAHEIGHT(2), .DATACHANNEL(1), .RELU(1)
   ) dut_relu (
      .clk(clk), .rst_n(rst_n), .in_valid(r_in_valid), .in_ready(r_in_ready),
      .in_data(r_in_data), .in_sof(r_in_sof), .out_valid(r_out_valid),
      .out_ready(r_out_ready), .out_data(r_out_data), .sof_err(r_sof_err)
   );

   fmap_stream_collector #(
      .BITWIDTH(8), .DATAWIDTH(1), .DATAHEIGHT(1), .DATACHANNEL(1), .RELU(0)
   ) dut_unit (
      .clk(clk), .rst_n(rst_n), .in_valid(u_in_valid), .in_ready(u_in_ready),
      .in_data(u_in_data), .in_sof(u_in_sof), .out_valid(u_out_valid),
      .out_ready(u_out_ready), .out_data(u_out_data), .sof_err(u_sof_err)
   );

   int checks = 0;
   int passes = 0;
   bit chk_en = 1'b0;

   task automatic check_output(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
      checks++;
      if (actual === expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %h, wanted %h", name, actual, expected);
      end
   endtask

   // Frame-level model: a slot array, a stream position and a holding flag.
   logic [7:0] m_mem [16];
   bit         m_hold;
   bit         m_err;
   int         m_pos;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
         m_hold = 1'b0;
         m_err  = 1'b0;
         m_pos  = 0;
      end else begin
         m_err = 1'b0;
         if (m_hold) begin
            if (out_ready) m_hold = 1'b0;
         end else if (in_valid) begin
            int p;
            p = in_sof ? 0 : m_pos;
            if (in_sof && m_pos != 0) m_err = 1'b1;
            m_mem[p] = in_data;
            if (p == 15) begin
               m_hold = 1'b1;
               m_pos  = 0;
            end else begin
               m_pos = p + 1;
            end
         end
      end
   end

   logic [127:0] exp_frame;

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 16; i++) exp_frame[i*8 +: 8] = m_mem[i];
         check_output("model_in_ready", in_ready, !m_hold);
         check_output("model_out_valid", out_valid, m_hold);
         check_output("model_sof_err", sof_err, m_err);
         check_output("model_out_data", out_data, exp_frame);
      end
   end

   // One beat on the 4x2x2 instance; called at posedge+1, returns at posedge+1.
   task automatic apply_stimulus(input logic [7:0] data, input logic sof);
      in_valid = 1'b1;
      in_data  = data;
      in_sof   = sof;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic release_frame();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   initial begin
      #2;
      rst_n  = 1'b0;
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_output("reset_out_valid", out_valid, 1'b0);
      check_output("reset_in_ready", in_ready, 1'b1);
      check_output("reset_sof_err", sof_err, 1'b0);
      check_output("reset_out_data", out_data, 128'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] frame of 1..16 with out_ready held high");
      out_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         if (k == 15) check_output("t1_valid_before_last", out_valid, 1'b0);
         apply_stimulus(8'(k + 1), 1'b0);
      end
      check_output("t1_valid_after_last", out_valid, 1'b1);
      check_output("t1_ready_in_hold", in_ready, 1'b0);
      check_output("t1_slot0", out_data[7:0], 8'h01);
      check_output("t1_slot15", out_data[127:120], 8'h10);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check_output("t1_valid_dropped", out_valid, 1'b0);
      check_output("t1_ready_back", in_ready, 1'b1);

      $display("[TB] frame of 0..15, held with in_valid high");
      for (int k = 0; k < 16; k++) apply_stimulus(8'(k), 1'b0);
      check_output("t2_slot5", out_data[5*8 +: 8], 8'h05);
      check_output("t2_slot12", out_data[12*8 +: 8], 8'h0C);
      check_output("t2_slot4", out_data[4*8 +: 8], 8'h04);
      in_valid = 1'b1;
      in_data  = 8'hEE;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         check_output("t2_hold_ready", in_ready, 1'b0);
         check_output("t2_hold_valid", out_valid, 1'b1);
      end
      check_output("t2_hold_slot0", out_data[7:0], 8'h00);
      in_valid = 1'b0;
      release_frame();
      check_output("t2_released", out_valid, 1'b0);
      for (int k = 0; k < 16; k++) apply_stimulus(8'(8'h20 + k), 1'b0);
      check_output("t2_frame2_slot9", out_data[9*8 +: 8], 8'h29);
      release_frame();

      $display("[TB] sof restart on the sixth beat");
      for (int k = 0; k < 5; k++) apply_stimulus(8'(8'h40 + k), 1'b0);
      apply_stimulus(8'h50, 1'b1);
      check_output("t3_sof_err_pulse", sof_err, 1'b1);
      apply_stimulus(8'h51, 1'b0);
      check_output("t3_sof_err_clear", sof_err, 1'b0);
      for (int k = 2; k < 15; k++) apply_stimulus(8'(8'h50 + k), 1'b0);
      check_output("t3_not_yet_valid", out_valid, 1'b0);
      apply_stimulus(8'h5F, 1'b0);
      check_output("t3_valid", out_valid, 1'b1);
      check_output("t3_slot0", out_data[7:0], 8'h50);
      check_output("t3_slot15", out_data[127:120], 8'h5F);
      release_frame();

      $display("[TB] asynchronous reset mid-frame");
      for (int k = 0; k < 7; k++) apply_stimulus(8'(8'h60 + k), 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      check_output("t4_rst_valid", out_valid, 1'b0);
      check_output("t4_rst_ready", in_ready, 1'b1);
      check_output("t4_rst_data", out_data, 128'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_output("t4_post_ready", in_ready, 1'b1);
      for (int k = 0; k < 16; k++) apply_stimulus(8'(8'h70 + k), (k == 0));
      check_output("t4_clean_valid", out_valid, 1'b1);
      check_output("t4_clean_slot3", out_data[3*8 +: 8], 8'h73);
      check_output("t4_clean_sof_err", sof_err, 1'b0);
      release_frame();

      $display("[TB] clamp of negative pixels");
      r_in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         case (k)
            0: r_in_data = 8'h80;
            1: r_in_data = 8'hFF;
            2: r_in_data = 8'h7F;
            default: r_in_data = 8'h01;
         endcase
         @(posedge clk);
         #1;
         if (k == 2) check_output("relu_not_yet_valid", r_out_valid, 1'b0);
      end
      r_in_valid = 1'b0;
      check_output("relu_valid", r_out_valid, 1'b1);
      check_output("relu_frame", r_out_data, 32'h017F0000);
      check_output("relu_ready_in_hold", r_in_ready, 1'b0);

      $display("[TB] single-pixel frames");
      u_in_valid = 1'b1;
      u_in_data  = 8'hA5;
      @(posedge clk);
      #1;
      check_output("unit_valid", u_out_valid, 1'b1);
      check_output("unit_data", u_out_data, 8'hA5);
      check_output("unit_ready_hold", u_in_ready, 1'b0);
      u_in_data = 8'h3C;
      u_in_sof  = 1'b1;
      @(posedge clk);
      #1;
      check_output("unit_held_data", u_out_data, 8'hA5);
      u_out_ready = 1'b1;
      @(posedge clk);
      #1;
      u_out_ready = 1'b0;
      check_output("unit_released", u_out_valid, 1'b0);
      check_output("unit_ready_fill", u_in_ready, 1'b1);
      @(posedge clk);
      #1;
      u_in_valid = 1'b0;
      u_in_sof   = 1'b0;
      check_output("unit_second_valid", u_out_valid, 1'b1);
      check_output("unit_second_data", u_out_data, 8'h3C);
      check_output("unit_sof_no_err", u_sof_err, 1'b0);

      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
